// File: rtl/regwr_arbiter.sv
// Register-file write-port arbiter.
// Merges the memory-load writeback path and the ALU writeback path onto the
// single register-file write port. Loads always win the port. ALU writes
// that cannot issue immediately wait in a small in-order buffer.
// Writes to the hardwired registers r0/r1 are discarded and reported on drop.
// busy_mask/hazard let decode stall on reads of registers with pending writes.
module regwr_arbiter #(
   parameter int DW    = 8,
   parameter int AW    = 3,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alu_req,
   input  logic [AW-1:0]            alu_addr,
   input  logic [DW-1:0]            alu_data,
   output logic                     alu_ready,
   input  logic                     mem_req,
   input  logic [AW-1:0]            mem_addr,
   input  logic [DW-1:0]            mem_data,
   input  logic                     flush,
   input  logic [AW-1:0]            rd_addrA,
   input  logic [AW-1:0]            rd_addrB,
   output logic                     wr_en,
   output logic [AW-1:0]            wr_addr,
   output logic [DW-1:0]            wr_data,
   output logic [(2**AW)-1:0]       busy_mask,
   output logic                     hazard,
   output logic                     drop,
   output logic [$clog2(DEPTH):0]   fifo_cnt
);

   localparam int NREG = 2**AW;
   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [AW-1:0]   fifo_addr [DEPTH];
   logic [DW-1:0]   fifo_data [DEPTH];
   logic [DEPTH-1:0] fifo_valid;
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   count;

   logic            fifo_empty;
   logic            alu_prot;
   logic            mem_prot;
   logic            alu_acc;
   logic            mem_issue;
   logic            alu_write;
   logic            drop_now;

   logic            issue_en;
   logic [AW-1:0]   issue_addr;
   logic [DW-1:0]   issue_data;
   logic            pop;
   logic            push;
   logic            bypass;

   logic [NREG-1:0] busy_raw;

   assign fifo_cnt   = count;
   assign fifo_empty = (count == '0);

   // The accept window depends only on the registered count, so a full buffer
   // refuses new ALU writes even in a cycle where its head is leaving.
   assign alu_ready  = (count < DEPTH_C);

   assign alu_prot   = (alu_addr[AW-1:1] == '0);
   assign mem_prot   = (mem_addr[AW-1:1] == '0);
   assign alu_acc    = alu_req && alu_ready && !flush;
   assign mem_issue  = mem_req && !mem_prot;

   // An ALU write racing a load to the same register is older than the load,
   // so it is simply dropped instead of being buffered behind it.
   assign alu_write  = alu_acc && !alu_prot && !(mem_issue && (alu_addr == mem_addr));
   assign drop_now   = (alu_acc && alu_prot) || (mem_req && mem_prot);

   // Pick the single write that owns the port this cycle: load, then buffer
   // head, then a fresh ALU write that may skip the buffer only when it is empty.
   always_comb begin
      issue_en   = 1'b0;
      issue_addr = '0;
      issue_data = '0;
      pop        = 1'b0;
      bypass     = 1'b0;
      if (mem_issue) begin
         issue_en   = 1'b1;
         issue_addr = mem_addr;
         issue_data = mem_data;
      end else if (!fifo_empty && !flush) begin
         pop = 1'b1;
         if (fifo_valid[head]) begin
            issue_en   = 1'b1;
            issue_addr = fifo_addr[head];
            issue_data = fifo_data[head];
         end
      end else if (fifo_empty && alu_write) begin
         issue_en   = 1'b1;
         issue_addr = alu_addr;
         issue_data = alu_data;
         bypass     = 1'b1;
      end
   end

   assign push = alu_write && !bypass;

   // ALU write buffer: in-order ring with per-entry valid bits so that entries
   // overtaken by a load to the same register still drain in sequence silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         fifo_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_addr[i] <= '0;
            fifo_data[i] <= '0;
         end
      end else if (flush) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         fifo_valid <= '0;
      end else begin
         if (mem_issue) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (fifo_addr[i] == mem_addr) begin
                  fifo_valid[i] <= 1'b0;
               end
            end
         end
         if (pop) begin
            fifo_valid[head] <= 1'b0;
            head             <= head + PW'(1);
         end
         if (push) begin
            fifo_addr[tail]  <= alu_addr;
            fifo_data[tail]  <= alu_data;
            fifo_valid[tail] <= 1'b1;
            tail             <= tail + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Register the chosen write toward the register file and the drop pulse;
   // address and data hold between writes to avoid needless toggling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         drop    <= 1'b0;
      end else begin
         wr_en <= issue_en;
         drop  <= drop_now;
         if (issue_en) begin
            wr_addr <= issue_addr;
            wr_data <= issue_data;
         end
      end
   end

   // Collect every register that still has a write in flight, either in the
   // output register or waiting in the buffer.
   always_comb begin
      busy_raw = '0;
      if (wr_en) begin
         busy_raw[wr_addr] = 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (fifo_valid[i]) begin
            busy_raw[fifo_addr[i]] = 1'b1;
         end
      end
   end

   assign busy_mask = {busy_raw[NREG-1:2], 2'b00};

   assign hazard = ((rd_addrA[AW-1:1] != '0) && busy_mask[rd_addrA]) ||
                   ((rd_addrB[AW-1:1] != '0) && busy_mask[rd_addrB]);

endmodule

// File: tb/tb_regwr_arbiter.sv
// Directed bench for regwr_arbiter with a queue-based reference model.
module tb_regwr_arbiter;

   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 2;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   alu_req = 1'b0;
   logic [AW-1:0]          alu_addr = '0;
   logic [DW-1:0]          alu_data = '0;
   logic                   alu_ready;
   logic                   mem_req = 1'b0;
   logic [AW-1:0]          mem_addr = '0;
   logic [DW-1:0]          mem_data = '0;
   logic                   flush = 1'b0;
   logic [AW-1:0]          rd_addrA = '0;
   logic [AW-1:0]          rd_addrB = '0;
   logic                   wr_en;
   logic [AW-1:0]          wr_addr;
   logic [DW-1:0]          wr_data;
   logic [(2**AW)-1:0]     busy_mask;
   logic                   hazard;
   logic                   drop;
   logic [$clog2(DEPTH):0] fifo_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            valid;
   } ent_t;

   ent_t          mq[$];
   logic          m_wr_en = 1'b0;
   logic [AW-1:0] m_wr_addr = '0;
   logic [DW-1:0] m_wr_data = '0;
   logic          m_drop = 1'b0;

   regwr_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_req   (alu_req),
      .alu_addr  (alu_addr),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .flush     (flush),
      .rd_addrA  (rd_addrA),
      .rd_addrB  (rd_addrB),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy_mask (busy_mask),
      .hazard    (hazard),
      .drop      (drop),
      .fifo_cnt  (fifo_cnt)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of the reference: the load wins, otherwise the oldest buffered
   // write leaves (silently if a later load overtook it), otherwise a new ALU
   // write goes straight out when nothing is waiting.
   task automatic modelStep();
      bit            acc;
      bit            mem_ok;
      bit            alu_ok;
      bit            nxt_en;
      logic [AW-1:0] na;
      logic [DW-1:0] nd;
      ent_t          e;
      ent_t          ne;
      if (!rst_n) begin
         m_wr_en   = 1'b0;
         m_wr_addr = '0;
         m_wr_data = '0;
         m_drop    = 1'b0;
         mq.delete();
      end else begin
         acc    = alu_req && (mq.size() < DEPTH) && !flush;
         mem_ok = mem_req && (mem_addr >= 3'd2);
         alu_ok = acc && (alu_addr >= 3'd2) && !(mem_ok && (alu_addr == mem_addr));
         nxt_en = 1'b0;
         na     = '0;
         nd     = '0;
         if (mem_ok) begin
            nxt_en = 1'b1;
            na     = mem_addr;
            nd     = mem_data;
            foreach (mq[i]) begin
               if (mq[i].addr == mem_addr) mq[i].valid = 1'b0;
            end
         end else if ((mq.size() > 0) && !flush) begin
            e = mq.pop_front();
            if (e.valid) begin
               nxt_en = 1'b1;
               na     = e.addr;
               nd     = e.data;
            end
         end else if (alu_ok) begin
            nxt_en = 1'b1;
            na     = alu_addr;
            nd     = alu_data;
            alu_ok = 1'b0;
         end
         if (alu_ok) begin
            ne.addr  = alu_addr;
            ne.data  = alu_data;
            ne.valid = 1'b1;
            mq.push_back(ne);
         end
         if (flush) mq.delete();
         m_wr_en = nxt_en;
         if (nxt_en) begin
            m_wr_addr = na;
            m_wr_data = nd;
         end
         m_drop = (acc && (alu_addr < 3'd2)) || (mem_req && (mem_addr < 3'd2));
      end
   endtask

   // Advance the reference model on every edge and on reset assertion.
   always @(posedge clk or negedge rst_n) modelStep();

   // Compare every DUT output against the model in the middle of each cycle.
   always @(negedge clk) begin
      logic [(2**AW)-1:0] b;
      logic               hz;
      b = '0;
      if (m_wr_en) b[m_wr_addr] = 1'b1;
      foreach (mq[i]) begin
         if (mq[i].valid) b[mq[i].addr] = 1'b1;
      end
      b[1:0] = 2'b00;
      hz = ((rd_addrA >= 3'd2) && b[rd_addrA]) || ((rd_addrB >= 3'd2) && b[rd_addrB]);
      checkOutput("cmp_wr_en", 32'(wr_en), 32'(m_wr_en));
      if (m_wr_en) begin
         checkOutput("cmp_wr_addr", 32'(wr_addr), 32'(m_wr_addr));
         checkOutput("cmp_wr_data", 32'(wr_data), 32'(m_wr_data));
      end
      checkOutput("cmp_drop", 32'(drop), 32'(m_drop));
      checkOutput("cmp_fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
      checkOutput("cmp_busy_mask", 32'(busy_mask), 32'(b));
      checkOutput("cmp_alu_ready", 32'(alu_ready), 32'(mq.size() < DEPTH));
      checkOutput("cmp_hazard", 32'(hazard), 32'(hz));
   end

   task automatic applyStimulus(input logic ar, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                input logic mr, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                                input logic fl);
      alu_req  = ar;
      alu_addr = aa;
      alu_data = ad;
      mem_req  = mr;
      mem_addr = ma;
      mem_data = md;
      flush    = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
   endtask

   // Directed scenarios with hand-computed expectations.
   initial begin
      #12;
      checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
      checkOutput("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
      checkOutput("rst_busy", 32'(busy_mask), 32'd0);
      checkOutput("rst_alu_ready", 32'(alu_ready), 32'd1);
      checkOutput("rst_hazard", 32'(hazard), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b0);
      checkOutput("unc_wr_en", 32'(wr_en), 32'd1);
      checkOutput("unc_wr_addr", 32'(wr_addr), 32'd3);
      checkOutput("unc_wr_data", 32'(wr_data), 32'h5A);
      checkOutput("unc_busy", 32'(busy_mask), 32'h08);
      idle();
      checkOutput("unc_wr_en_off", 32'(wr_en), 32'd0);
      checkOutput("unc_busy_off", 32'(busy_mask), 32'h00);

      applyStimulus(1'b1, 3'd4, 8'h22, 1'b1, 3'd2, 8'h11, 1'b0);
      checkOutput("cont_wr_addr", 32'(wr_addr), 32'd2);
      checkOutput("cont_wr_data", 32'(wr_data), 32'h11);
      checkOutput("cont_fifo_cnt", 32'(fifo_cnt), 32'd1);
      checkOutput("cont_ready", 32'(alu_ready), 32'd1);
      idle();
      checkOutput("cont_wr2_addr", 32'(wr_addr), 32'd4);
      checkOutput("cont_wr2_data", 32'(wr_data), 32'h22);
      checkOutput("cont_fifo_empty", 32'(fifo_cnt), 32'd0);

      applyStimulus(1'b1, 3'd5, 8'h50, 1'b1, 3'd2, 8'h21, 1'b0);
      checkOutput("bp_a_cnt", 32'(fifo_cnt), 32'd1);
      applyStimulus(1'b1, 3'd6, 8'h60, 1'b1, 3'd3, 8'h31, 1'b0);
      checkOutput("bp_b_cnt", 32'(fifo_cnt), 32'd2);
      checkOutput("bp_b_ready", 32'(alu_ready), 32'd0);
      applyStimulus(1'b1, 3'd7, 8'h70, 1'b1, 3'd4, 8'h41, 1'b0);
      checkOutput("bp_c_cnt", 32'(fifo_cnt), 32'd2);
      applyStimulus(1'b1, 3'd7, 8'h70, 1'b1, 3'd2, 8'h22, 1'b0);
      checkOutput("bp_d_addr", 32'(wr_addr), 32'd2);
      applyStimulus(1'b1, 3'd7, 8'h70, 1'b0, 3'd0, 8'h00, 1'b0);
      checkOutput("bp_e_addr", 32'(wr_addr), 32'd5);
      checkOutput("bp_e_data", 32'(wr_data), 32'h50);
      checkOutput("bp_e_cnt", 32'(fifo_cnt), 32'd1);
      applyStimulus(1'b1, 3'd7, 8'h70, 1'b0, 3'd0, 8'h00, 1'b0);
      checkOutput("bp_f_addr", 32'(wr_addr), 32'd6);
      checkOutput("bp_f_cnt", 32'(fifo_cnt), 32'd1);
      idle();
      checkOutput("bp_g_addr", 32'(wr_addr), 32'd7);
      checkOutput("bp_g_data", 32'(wr_data), 32'h70);
      idle();
      checkOutput("bp_done", 32'(wr_en), 32'd0);

      applyStimulus(1'b1, 3'd5, 8'hAA, 1'b1, 3'd2, 8'h33, 1'b0);
      checkOutput("kill_cnt", 32'(fifo_cnt), 32'd1);
      applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'hBB, 1'b0);
      checkOutput("kill_wr_data", 32'(wr_data), 32'hBB);
      checkOutput("kill_busy", 32'(busy_mask), 32'h20);
      idle();
      checkOutput("kill_silent", 32'(wr_en), 32'd0);
      checkOutput("kill_cnt0", 32'(fifo_cnt), 32'd0);

      applyStimulus(1'b1, 3'd1, 8'h77, 1'b0, 3'd0, 8'h00, 1'b0);
      checkOutput("prot_wr_en", 32'(wr_en), 32'd0);
      checkOutput("prot_drop", 32'(drop), 32'd1);
      idle();
      checkOutput("prot_drop_off", 32'(drop), 32'd0);
      applyStimulus(1'b1, 3'd3, 8'h44, 1'b1, 3'd0, 8'h99, 1'b0);
      checkOutput("prot_mem_slot", 32'(wr_addr), 32'd3);
      checkOutput("prot_mem_data", 32'(wr_data), 32'h44);
      checkOutput("prot_mem_drop", 32'(drop), 32'd1);

      applyStimulus(1'b1, 3'd6, 8'h66, 1'b1, 3'd2, 8'h12, 1'b0);
      rd_addrA = 3'd6;
      #1;
      checkOutput("haz_r6", 32'(hazard), 32'd1);
      rd_addrA = 3'd0;
      #1;
      checkOutput("haz_r0", 32'(hazard), 32'd0);
      idle();
      checkOutput("haz_drain_addr", 32'(wr_addr), 32'd6);
      idle();

      applyStimulus(1'b1, 3'd4, 8'h55, 1'b1, 3'd4, 8'h66, 1'b0);
      checkOutput("same_data", 32'(wr_data), 32'h66);
      checkOutput("same_cnt", 32'(fifo_cnt), 32'd0);
      idle();
      checkOutput("same_no_alu", 32'(wr_en), 32'd0);

      applyStimulus(1'b1, 3'd5, 8'h01, 1'b1, 3'd2, 8'hA1, 1'b0);
      applyStimulus(1'b1, 3'd6, 8'h02, 1'b1, 3'd3, 8'hA2, 1'b0);
      checkOutput("fl_full", 32'(fifo_cnt), 32'd2);
      applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1);
      checkOutput("fl_cnt", 32'(fifo_cnt), 32'd0);
      checkOutput("fl_ready", 32'(alu_ready), 32'd1);
      checkOutput("fl_wr_en", 32'(wr_en), 32'd0);
      idle();
      checkOutput("fl_wr_en2", 32'(wr_en), 32'd0);

      applyStimulus(1'b1, 3'd5, 8'h03, 1'b1, 3'd2, 8'hA3, 1'b0);
      applyStimulus(1'b1, 3'd7, 8'h04, 1'b1, 3'd3, 8'hA4, 1'b1);
      checkOutput("flm_addr", 32'(wr_addr), 32'd3);
      checkOutput("flm_data", 32'(wr_data), 32'hA4);
      checkOutput("flm_cnt", 32'(fifo_cnt), 32'd0);
      idle();
      checkOutput("flm_quiet", 32'(wr_en), 32'd0);

      applyStimulus(1'b1, 3'd5, 8'h10, 1'b1, 3'd2, 8'h20, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mrst_wr_en", 32'(wr_en), 32'd0);
      checkOutput("mrst_wr_addr", 32'(wr_addr), 32'd0);
      checkOutput("mrst_wr_data", 32'(wr_data), 32'd0);
      checkOutput("mrst_cnt", 32'(fifo_cnt), 32'd0);
      checkOutput("mrst_busy", 32'(busy_mask), 32'd0);
      alu_req = 1'b0;
      mem_req = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle();
      checkOutput("mrst_discard", 32'(wr_en), 32'd0);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
